// File: rtl/mac_tcdm_mux.sv
// ---------------------------------------------------------------------------
// mac_tcdm_mux
//
// Funnels the MP TCDM master ports of the MAC engine onto one shared TCDM
// slave port. Requests are arbitrated (round-robin by default), and every
// granted transaction records its winning port in an in-order routing queue.
// Each response is then steered back to the port at the head of that queue.
//
// Parameters
//   MP           number of upstream TCDM ports (2..8)
//   OUTSTANDING  max granted-but-unanswered transactions (1..8)
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_req/in_gnt        per-port request / grant
//   in_add/in_wen/in_be/in_data   per-port request fields (wen: 1 = read)
//   in_r_data            shared-port read data, broadcast to every port
//   in_r_valid           per-port response valid (one-hot or zero)
//   out_req/out_gnt      shared-port request / grant
//   out_add/out_wen/out_be/out_data  shared-port request fields
//   out_r_data/out_r_valid           shared-port response
//   err_o                sticky: response seen with no transaction pending
//
// Build option
//   MAC_TCDM_MUX_FIXED_PRIO_EN : when defined, the lowest requesting index
//   always wins and no round-robin pointer is kept. Default is round-robin.
// ---------------------------------------------------------------------------
module mac_tcdm_mux #(
  parameter int unsigned MP          = 4,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic [MP-1:0]        in_req,
  output logic [MP-1:0]        in_gnt,
  input  logic [MP-1:0][31:0]  in_add,
  input  logic [MP-1:0]        in_wen,
  input  logic [MP-1:0][3:0]   in_be,
  input  logic [MP-1:0][31:0]  in_data,
  output logic [MP-1:0][31:0]  in_r_data,
  output logic [MP-1:0]        in_r_valid,

  output logic                 out_req,
  input  logic                 out_gnt,
  output logic [31:0]          out_add,
  output logic                 out_wen,
  output logic [3:0]           out_be,
  output logic [31:0]          out_data,
  input  logic [31:0]          out_r_data,
  input  logic                 out_r_valid,

  output logic                 err_o
);

  localparam int unsigned IDX_W = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;
  logic             push;
  logic             pop;
  logic             not_full;

  logic [IDX_W-1:0] fifo_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  // Queue pointers wrap at OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

`ifdef MAC_TCDM_MUX_FIXED_PRIO_EN

  // Fixed priority: the lowest-numbered requesting port wins.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < MP; i++) begin
      if (!found && in_req[IDX_W'(i)]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

`else

  logic [IDX_W-1:0] rr_q;

  // Round-robin: scan upward from rr_q, wrapping past MP-1 back to port 0,
  // and take the first requester. MP may be a non-power of two, so the
  // wrap is an explicit subtraction rather than truncation.
  always_comb begin
    logic        found;
    int unsigned cand;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < MP; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= MP) begin
        cand = cand - MP;
      end
      if (!found && in_req[IDX_W'(cand)]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  // The pointer moves just past the port that completed a handshake, so a
  // stalled grant leaves the rotation untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (push) begin
      if (winner == IDX_W'(MP - 1)) begin
        rr_q <= '0;
      end else begin
        rr_q <= winner + IDX_W'(1);
      end
    end
  end

`endif

  // A full queue blocks new requests even if a response frees a slot in the
  // same cycle; this keeps out_req independent of out_r_valid.
  assign not_full = (count_q < CNT_W'(OUTSTANDING));
  assign out_req  = (|in_req) & not_full;
  assign push     = out_req & out_gnt;
  assign pop      = out_r_valid & (count_q != '0);
  assign head     = fifo_q[rd_ptr_q];

  // While nothing is being requested the field mux parks on port 0 so the
  // shared-port fields stay stable instead of following the arbiter.
  assign sel      = out_req ? winner : '0;
  assign out_add  = in_add[sel];
  assign out_wen  = in_wen[sel];
  assign out_be   = in_be[sel];
  assign out_data = in_data[sel];

  // Grant is only passed back to the port that actually won this cycle.
  always_comb begin
    in_gnt = '0;
    if (push) begin
      in_gnt[winner] = 1'b1;
    end
  end

  // Responses go to the oldest outstanding requester; read data is simply
  // broadcast since only the flagged port will consume it.
  always_comb begin
    in_r_valid = '0;
    if (pop) begin
      in_r_valid[head] = 1'b1;
    end
  end

  assign in_r_data = {MP{out_r_data}};

  // Routing queue storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A response with nothing pending means the slave broke its contract (or
  // answered a transaction discarded by reset). Latched until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (out_r_valid && (count_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mac_tcdm_mux.sv
// ---------------------------------------------------------------------------
// tb_mac_tcdm_mux
//
// Self-checking bench for mac_tcdm_mux (MP = 4, OUTSTANDING = 2). A queue-
// based reference model tracks which port owns each outstanding transaction;
// directed scenarios and a randomized run compare the DUT against it.
// Honours MAC_TCDM_MUX_FIXED_PRIO_EN to expect fixed-priority arbitration.
// ---------------------------------------------------------------------------
module tb_mac_tcdm_mux;

  localparam int MP  = 4;
  localparam int OUT = 2;
`ifdef MAC_TCDM_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                clk_i;
  logic                rst_ni;
  logic [MP-1:0]       in_req;
  logic [MP-1:0]       in_gnt;
  logic [MP-1:0][31:0] in_add;
  logic [MP-1:0]       in_wen;
  logic [MP-1:0][3:0]  in_be;
  logic [MP-1:0][31:0] in_data;
  logic [MP-1:0][31:0] in_r_data;
  logic [MP-1:0]       in_r_valid;
  logic                out_req;
  logic                out_gnt;
  logic [31:0]         out_add;
  logic                out_wen;
  logic [3:0]          out_be;
  logic [31:0]         out_data;
  logic [31:0]         out_r_data;
  logic                out_r_valid;
  logic                err_o;

  int n_cmp;
  int n_fail;

  // Reference model state: ports owning outstanding transactions, oldest first.
  int q_m[$];
  int rr_m;
  bit err_m;

  logic          exp_out_req;
  int            exp_win;
  logic [MP-1:0] exp_gnt;
  logic [MP-1:0] exp_rv;

  mac_tcdm_mux #(.MP(MP), .OUTSTANDING(OUT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_req      (in_req),
    .in_gnt      (in_gnt),
    .in_add      (in_add),
    .in_wen      (in_wen),
    .in_be       (in_be),
    .in_data     (in_data),
    .in_r_data   (in_r_data),
    .in_r_valid  (in_r_valid),
    .out_req     (out_req),
    .out_gnt     (out_gnt),
    .out_add     (out_add),
    .out_wen     (out_wen),
    .out_be      (out_be),
    .out_data    (out_data),
    .out_r_data  (out_r_data),
    .out_r_valid (out_r_valid),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int pick_winner();
    if (FIXED) begin
      for (int i = 0; i < MP; i++) if (in_req[i]) return i;
    end else begin
      for (int off = 0; off < MP; off++) begin
        int p;
        p = (rr_m + off) % MP;
        if (in_req[p]) return p;
      end
    end
    return 0;
  endfunction

  task model_eval();
    exp_out_req = (in_req != '0) && (q_m.size() < OUT);
    exp_win     = pick_winner();
    exp_gnt     = (exp_out_req && out_gnt) ? MP'(1 << exp_win) : '0;
    exp_rv      = (out_r_valid && q_m.size() > 0) ? MP'(1 << q_m[0]) : '0;
  endtask

  task model_commit();
    model_eval();
    if (out_r_valid) begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      else err_m = 1'b1;
    end
    if (exp_out_req && out_gnt) begin
      q_m.push_back(exp_win);
      rr_m = (exp_win + 1) % MP;
    end
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task tick();
    model_commit();
    @(posedge clk_i);
    #1;
  endtask

  task applyStimulus(input logic [MP-1:0] req, input logic gnt, input logic rv);
    in_req      = req;
    out_gnt     = gnt;
    out_r_valid = rv;
  endtask

  task do_reset();
    applyStimulus('0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    q_m.delete();
    rr_m  = 0;
    err_m = 1'b0;
  endtask

  task drain();
    applyStimulus('0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (q_m.size() == 0) break;
      out_r_valid = 1'b1;
      tick();
    end
    out_r_valid = 1'b0;
  endtask

  task test_reset();
    applyStimulus('0, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #3;
    n_cmp++;
    if (out_req !== 1'b0 || in_gnt !== '0 || in_r_valid !== '0 || err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: out_req=%b in_gnt=%b in_r_valid=%b err=%b, want 0/0/0/0",
               out_req, in_gnt, in_r_valid, err_o);
    end
    do_reset();
  endtask

  task test_single_port();
    do_reset();
    in_add[1] = 32'h0000_1000;
    in_wen[1] = 1'b1;
    applyStimulus(4'b0010, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (in_gnt !== 4'b0010 || out_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_gnt: in_gnt=%b out_req=%b, want 0010/1", in_gnt, out_req);
    end
    n_cmp++;
    if (out_add !== 32'h0000_1000 || out_wen !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_fields: add=%h wen=%b, want 00001000/1", out_add, out_wen);
    end
    tick();
    applyStimulus('0, 1'b0, 1'b1);
    out_r_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (in_r_valid !== 4'b0010 || in_r_data[1] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL single_resp: r_valid=%b r_data=%h, want 0010/deadbeef",
               in_r_valid, in_r_data[1]);
    end
    tick();
    out_r_valid = 1'b0;
  endtask

  task test_round_robin();
    int prev;
    do_reset();
    prev = 0;
    for (int c = 0; c < 6; c++) begin
      int want;
      want = FIXED ? 0 : (c % MP);
      applyStimulus(4'b1111, 1'b1, c > 0);
      #1;
      n_cmp++;
      if (in_gnt !== MP'(1 << want)) begin
        n_fail++;
        $display("[TB] FAIL rr_grant c=%0d: in_gnt=%b, want port %0d", c, in_gnt, want);
      end
      if (c > 0) begin
        n_cmp++;
        if (in_r_valid !== MP'(1 << prev)) begin
          n_fail++;
          $display("[TB] FAIL rr_route c=%0d: in_r_valid=%b, want port %0d", c, in_r_valid, prev);
        end
      end
      prev = want;
      tick();
    end
    drain();
  endtask

  task test_back_to_back_full();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (out_req !== 1'b0 || in_gnt !== '0) begin
        n_fail++;
        $display("[TB] FAIL full_block c=%0d: out_req=%b in_gnt=%b, want 0/0000", c, out_req, in_gnt);
      end
      tick();
    end
    out_r_valid = 1'b1;
    #1;
    n_cmp++;
    if (out_req !== 1'b0 || in_r_valid !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL full_no_bypass: out_req=%b r_valid=%b, want 0/0001", out_req, in_r_valid);
    end
    tick();
    out_r_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_resume: out_req=%b, want 1", out_req);
    end
    drain();
  endtask

  task test_gnt_stall();
    logic [31:0] addr;
    do_reset();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    tick();
    drain();
    addr      = $urandom;
    in_add[3] = addr;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (in_gnt !== '0 || out_add !== addr || out_req !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL stall c=%0d: in_gnt=%b add=%h req=%b, want 0000/%h/1",
                 c, in_gnt, out_add, out_req, addr);
      end
      tick();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    #1;
    model_eval();
    n_cmp++;
    if (in_gnt !== exp_gnt) begin
      n_fail++;
      $display("[TB] FAIL stall_rr_kept: in_gnt=%b, want %b", in_gnt, exp_gnt);
    end
    tick();
    drain();
  endtask

  task test_spurious();
    do_reset();
    applyStimulus('0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (in_r_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL spurious_rv: in_r_valid=%b, want 0000", in_r_valid);
    end
    tick();
    out_r_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (err_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL spurious_err c=%0d: err_o=%b, want 1", c, err_o);
      end
      tick();
    end
    do_reset();
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL spurious_clear: err_o=%b, want 0", err_o);
    end
  endtask

  task test_reset_mid();
    do_reset();
    applyStimulus('0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0101, 1'b1, 1'b0);
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_err: err_o=%b, want 0", err_o);
    end
    do_reset();
    in_req = 4'b1111;
    #1;
    n_cmp++;
    if (out_req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_count: out_req=%b, want 1", out_req);
    end
    applyStimulus('0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (in_r_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_late_rv: in_r_valid=%b, want 0000", in_r_valid);
    end
    tick();
    out_r_valid = 1'b0;
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_late_err: err_o=%b, want 1", err_o);
    end
  endtask

  task test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < MP; k++) begin
        in_add[k]  = $urandom;
        in_data[k] = $urandom;
        in_be[k]   = 4'($urandom);
        in_wen[k]  = 1'($urandom);
      end
      out_r_data = $urandom;
      applyStimulus(MP'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    (q_m.size() > 0) && ($urandom_range(0, 2) != 0));
      #1;
      model_eval();
      n_cmp++;
      if (out_req !== exp_out_req || in_gnt !== exp_gnt) begin
        n_fail++;
        $display("[TB] FAIL rand_req c=%0d: out_req=%b in_gnt=%b, want %b/%b",
                 c, out_req, in_gnt, exp_out_req, exp_gnt);
      end
      n_cmp++;
      if (in_r_valid !== exp_rv || err_o !== err_m) begin
        n_fail++;
        $display("[TB] FAIL rand_resp c=%0d: r_valid=%b err=%b, want %b/%b",
                 c, in_r_valid, err_o, exp_rv, err_m);
      end
      if (exp_out_req) begin
        n_cmp++;
        if (out_add !== in_add[exp_win] || out_data !== in_data[exp_win] ||
            out_be !== in_be[exp_win] || out_wen !== in_wen[exp_win]) begin
          n_fail++;
          $display("[TB] FAIL rand_fields c=%0d: add=%h data=%h be=%h wen=%b, want port %0d",
                   c, out_add, out_data, out_be, out_wen, exp_win);
        end
      end
      if (exp_rv != '0) begin
        for (int k = 0; k < MP; k++) begin
          n_cmp++;
          if (in_r_data[k] !== out_r_data) begin
            n_fail++;
            $display("[TB] FAIL rand_rdata c=%0d k=%0d: got %h, want %h", c, k, in_r_data[k], out_r_data);
          end
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_ni      = 1'b0;
    in_req      = '0;
    in_add      = '0;
    in_wen      = '1;
    in_be       = '1;
    in_data     = '0;
    out_gnt     = 1'b0;
    out_r_data  = '0;
    out_r_valid = 1'b0;
    q_m.delete();
    rr_m  = 0;
    err_m = 1'b0;
    #2;
    test_reset();
    test_single_port();
    test_round_robin();
    test_back_to_back_full();
    test_gnt_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tcdm_mux.md
# mac_tcdm_mux

Request/response multiplexer between the MP TCDM master ports of the MAC engine and a single shared TCDM slave port (one memory bank or one interconnect port). Arbitrates the MP streamer requests onto the one port and tracks granted transactions in an in-order queue so each response returns to the port that issued it. Instantiated directly downstream of the MAC engine's TCDM ports.

## Interface
- MP, 4: number of upstream TCDM ports (2..8)
- OUTSTANDING, 2: maximum granted-but-unanswered transactions (1..8); depth of the routing queue
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- in_req  in  MP  per-port request
- in_gnt  out  MP  per-port grant
- in_add  in  MP×32  per-port byte address
- in_wen  in  MP  per-port write-enable-n (1 = read, 0 = write)
- in_be  in  MP×4  per-port byte enables
- in_data  in  MP×32  per-port write data
- in_r_data  out  MP×32  read data, same word broadcast to all ports
- in_r_valid  out  MP  per-port response valid, at most one bit set
- out_req  out  1  shared-port request
- out_gnt  in  1  shared-port grant
- out_add  out  32  shared-port address
- out_wen  out  1  shared-port write-enable-n
- out_be  out  4  shared-port byte enables
- out_data  out  32  shared-port write data
- out_r_data  in  32  shared-port read data
- out_r_valid  in  1  shared-port response valid
- err_o  out  1  sticky protocol error

## Operation
- Slave contract: exactly one out_r_valid per granted request (reads and writes), in grant order, one or more cycles after the grant.
- Queue: OUTSTANDING-entry FIFO of winner indices ($clog2(MP) bits), count register 0..OUTSTANDING.
- out_req = (|in_req) & (count < OUTSTANDING). No full bypass: a pop in the same cycle does not enable a grant while full.
- Winner: round-robin; first requesting port at or after pointer rr, wrapping MP-1 → 0. out_add/wen/be/data mux the winner's fields; undefined-but-stable (winner 0 fields) when out_req = 0.
- in_gnt[k] = out_req & out_gnt & (winner == k); all other bits 0.
- Handshake (out_req & out_gnt): push winner index; rr ← (winner+1) mod MP.
- out_r_valid with count > 0: in_r_valid[head] = 1, in_r_data[*] = out_r_data; pop.
- Push and pop in same cycle: count unchanged, both pointers advance.
- out_r_valid with count == 0: no in_r_valid asserted, count stays 0, err_o set; cleared only by reset.

## Timing
- Request path fully combinational: in_req → out_req, out_gnt → in_gnt in the same cycle; zero added latency.
- Response path combinational: out_r_valid → in_r_valid same cycle.
- Reset values: rr = 0, count = 0, queue pointers = 0, err_o = 0; in_gnt = 0, in_r_valid = 0, out_req = 0 whenever in_req = 0.
- Reset mid-operation discards outstanding entries; a response arriving after reset release sets err_o.
- Throughput: one grant per cycle while not full; with OUTSTANDING = 1 and 1-cycle slave latency, one grant every 2 cycles.

## Configuration
- MAC_TCDM_MUX_FIXED_PRIO_EN defined: fixed priority, lowest requesting index wins, rr register not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Single port: in_req = 4'b0010, read at 0x1000, slave gnt immediate, r_valid next cycle with 0xDEADBEEF -> in_gnt = 4'b0010 same cycle, in_r_valid = 4'b0010 with in_r_data = 0xDEADBEEF one cycle later.
- All 4 ports requesting continuously, gnt always 1, 1-cycle latency, OUTSTANDING = 2 -> grants 0,1,2,3,0 in consecutive cycles; responses routed in the same order (FIXED_PRIO: port 0 every cycle).
- Slave holds out_r_valid low for 5 cycles after 2 grants -> out_req drops to 0 while count = 2; resumes the cycle after first response.
- out_gnt low for 3 cycles with in_req = 4'b1000 -> in_gnt = 0, out_add stable, no queue push, rr unchanged.
- Spurious out_r_valid with empty queue -> in_r_valid = 0, err_o = 1 and held until rst_ni low.
- Reset asserted with 2 outstanding -> count = 0, err_o = 0 after reset; late r_valid sets err_o = 1.
